// File: rtl/fas_pkg.sv
// FAS analysis shared types.
// Bin format, magnitude type and FSM encoding.
package fas_pkg;

   localparam int NBIN = 16;
   localparam int DW   = 16;
   localparam int MW   = 32;
   localparam int KW   = $clog2(NBIN);

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;

   typedef logic [MW-1:0] mag_t;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

endpackage

// File: rtl/fas_mag_sq.sv
// Magnitude squared of one complex bin.
// Signed 8.8 in, unsigned 16.16 out; cannot overflow.
module fas_mag_sq
   import fas_pkg::*;
(
   input  logic [2*DW-1:0] bin,
   output logic [MW-1:0]   mag
);

   cplx_t              c;
   logic signed [MW-1:0] re_x;
   logic signed [MW-1:0] im_x;
   logic signed [MW-1:0] pr;
   logic signed [MW-1:0] pi;

   assign c    = bin;
   assign re_x = MW'(c.re);
   assign im_x = MW'(c.im);
   assign pr   = re_x * re_x;
   assign pi   = im_x * im_x;
   assign mag  = $unsigned(pr) + $unsigned(pi);

endmodule

// File: rtl/fas_analysis.sv
// FAS analysis stage: dominant-bin search over
// double-buffered 16-bin FFT frames.
module fas_analysis
   import fas_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        fft_valid,
   input  logic [31:0] fft_d0,
   input  logic [31:0] fft_d1,
   input  logic [31:0] fft_d2,
   input  logic [31:0] fft_d3,
   input  logic [31:0] fft_d4,
   input  logic [31:0] fft_d5,
   input  logic [31:0] fft_d6,
   input  logic [31:0] fft_d7,
   input  logic [31:0] fft_d8,
   input  logic [31:0] fft_d9,
   input  logic [31:0] fft_d10,
   input  logic [31:0] fft_d11,
   input  logic [31:0] fft_d12,
   input  logic [31:0] fft_d13,
   input  logic [31:0] fft_d14,
   input  logic [31:0] fft_d15,
   output logic [3:0]  freq,
   output logic        done,
   output logic [31:0] peak_mag,
   output logic        busy,
   output logic        overflow
);

   logic [31:0]   frame [NBIN];
   logic [31:0]   bank  [2][NBIN];
   state_t        state;
   state_t        state_nx;
   logic [1:0]    full;
   logic [1:0]    full_eff;
   logic [1:0]    full_nx;
   logic          wptr;
   logic          wptr_nx;
   logic          wsel;
   logic          accept;
   logic          last;
   logic          start;
   logic          upd;
   logic [KW-1:0] k;
   logic [KW-1:0] idx;
   logic [KW-1:0] idx_nx;
   mag_t          mx;
   mag_t          mx_nx;
   mag_t          m;

   assign frame = '{fft_d0, fft_d1, fft_d2, fft_d3,
                    fft_d4, fft_d5, fft_d6, fft_d7,
                    fft_d8, fft_d9, fft_d10, fft_d11,
                    fft_d12, fft_d13, fft_d14, fft_d15};

   // A bank on its last bin is free for a write in the same cycle.
   assign last     = (state == RUN) && (k == KW'(NBIN-1));
   assign full_eff = full & ~(last ? {wptr, ~wptr} : 2'b00);
   assign wsel     = full_eff[0];
   assign accept   = fft_valid && !(&full_eff);
   assign full_nx  = full_eff | (accept ? {wsel, ~wsel} : 2'b00);
   assign busy     = (state == RUN) || (|full);

   fas_mag_sq u_mag (
      .bin (bank[wptr][k]),
      .mag (m)
   );

   assign upd    = (k == '0) || (m > mx);
   assign mx_nx  = upd ? m : mx;
   assign idx_nx = upd ? k : idx;

   always_comb begin
      state_nx = state;
      wptr_nx  = wptr;
      start    = 1'b0;
      unique case (state)
         IDLE: begin
            if (|full) begin
               state_nx = RUN;
               wptr_nx  = ~full[0];
               start    = 1'b1;
            end else if (accept) begin
               state_nx = RUN;
               wptr_nx  = wsel;
               start    = 1'b1;
            end
         end
         RUN: begin
            if (last) begin
               // The other bank, if full, is the older frame.
               if (full[~wptr]) begin
                  wptr_nx = ~wptr;
                  start   = 1'b1;
               end else if (accept) begin
                  wptr_nx = wsel;
                  start   = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         wptr  <= 1'b0;
         full  <= 2'b00;
      end else begin
         state <= state_nx;
         wptr  <= wptr_nx;
         full  <= full_nx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k        <= '0;
         mx       <= '0;
         idx      <= '0;
         freq     <= '0;
         peak_mag <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= last;
         if (fft_valid && !accept) overflow <= 1'b1;
         if (start) begin
            k   <= '0;
            mx  <= '0;
            idx <= '0;
         end else if (state == RUN) begin
            k   <= k + 1'b1;
            mx  <= mx_nx;
            idx <= idx_nx;
         end
         if (last) begin
            freq     <= idx_nx;
            peak_mag <= mx_nx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < NBIN; i++)
               bank[b][i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < NBIN; i++)
            bank[wsel][i] <= frame[i];
      end
   end

endmodule

// File: tb/tb_fas_analysis.sv
// Directed bench for fas_analysis.
// Hand-computed dominant bins, latencies and overrun.
module tb_fas_analysis;

   typedef logic [31:0] frame_t [16];

   logic        clk = 1'b0;
   logic        rst;
   logic        fft_valid;
   frame_t      d;
   logic [3:0]  freq;
   logic        done;
   logic [31:0] peak_mag;
   logic        busy;
   logic        overflow;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int q_cyc  [$];
   int q_freq [$];
   int q_mag  [$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (done) begin
         q_cyc.push_back(cyc);
         q_freq.push_back(int'(freq));
         q_mag.push_back(int'(peak_mag));
      end
   end

   fas_analysis dut (
      .clk       (clk),
      .rst       (rst),
      .fft_valid (fft_valid),
      .fft_d0    (d[0]),
      .fft_d1    (d[1]),
      .fft_d2    (d[2]),
      .fft_d3    (d[3]),
      .fft_d4    (d[4]),
      .fft_d5    (d[5]),
      .fft_d6    (d[6]),
      .fft_d7    (d[7]),
      .fft_d8    (d[8]),
      .fft_d9    (d[9]),
      .fft_d10   (d[10]),
      .fft_d11   (d[11]),
      .fft_d12   (d[12]),
      .fft_d13   (d[13]),
      .fft_d14   (d[14]),
      .fft_d15   (d[15]),
      .freq      (freq),
      .done      (done),
      .peak_mag  (peak_mag),
      .busy      (busy),
      .overflow  (overflow)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic pulse(input frame_t f, output int c);
      @(negedge clk);
      d         = f;
      fft_valid = 1'b1;
      c         = cyc;
   endtask

   task automatic quiet();
      @(negedge clk);
      fft_valid = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget);
      int i = 0;
      while (q_cyc.size() < n && i < budget) begin
         quiet();
         i++;
      end
      quiet();
      check("done_cnt", q_cyc.size(), n);
   endtask

   task automatic clear_q();
      q_cyc.delete();
      q_freq.delete();
      q_mag.delete();
   endtask

   frame_t f;
   frame_t f_lo;
   frame_t f_hi;
   int     t;
   int     t2;
   int     t3;
   int     ts [64];

   initial begin
      rst       = 1'b0;
      fft_valid = 1'b0;
      d         = '{default: '0};

      f_lo     = '{default: '0};
      f_lo[1]  = 32'h0100_0000;
      f_lo[15] = 32'h0000_0080;
      f_hi     = '{default: '0};
      f_hi[1]  = 32'h0000_0080;
      f_hi[15] = 32'h0200_0000;

      repeat (3) @(negedge clk);
      check("rst_freq", freq, 0);
      check("rst_done", done, 0);
      check("rst_peak", peak_mag, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
      rst = 1'b1;

      // reset in the middle of a frame
      pulse(f_lo, t);
      repeat (5) quiet();
      check("mid_busy", busy, 1);
      #2 rst = 1'b0;
      #1;
      check("arst_freq", freq, 0);
      check("arst_done", done, 0);
      check("arst_peak", peak_mag, 0);
      check("arst_busy", busy, 0);
      check("arst_ovf", overflow, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      clear_q();
      repeat (20) quiet();
      check("arst_nodone", q_cyc.size(), 0);
      check("arst_idle", busy, 0);

      // single tone
      pulse(f_lo, t);
      wait_done(1, 40);
      if (q_cyc.size() > 0) begin
         check("tone_lat", q_cyc[0] - t, 17);
         check("tone_freq", q_freq[0], 1);
         check("tone_peak", q_mag[0], 32'h0001_0000);
      end
      repeat (10) quiet();
      check("hold_freq", freq, 1);
      check("hold_peak", peak_mag, 32'h0001_0000);
      check("hold_busy", busy, 0);
      clear_q();

      // tie with negative real part
      f    = '{default: '0};
      f[3] = 32'hFF00_0000;
      f[9] = 32'h0000_0100;
      pulse(f, t);
      wait_done(1, 40);
      if (q_cyc.size() > 0) begin
         check("tie_freq", q_freq[0], 3);
         check("tie_peak", q_mag[0], 32'h0001_0000);
      end
      clear_q();

      // most negative value on both parts
      f    = '{default: '0};
      f[7] = 32'h8000_8000;
      pulse(f, t);
      wait_done(1, 40);
      if (q_cyc.size() > 0) begin
         check("ext_freq", q_freq[0], 7);
         check("ext_peak", q_mag[0], 32'h8000_0000);
      end
      clear_q();

      // all-zero frame
      f = '{default: '0};
      pulse(f, t);
      wait_done(1, 40);
      if (q_cyc.size() > 0) begin
         check("zero_lat", q_cyc[0] - t, 17);
         check("zero_freq", q_freq[0], 0);
         check("zero_peak", q_mag[0], 0);
      end
      clear_q();

      // streaming, one frame every 16 cycles
      for (int i = 0; i < 64; i++) begin
         pulse((i % 2 == 1) ? f_hi : f_lo, ts[i]);
         repeat (15) quiet();
      end
      wait_done(64, 60);
      check("str_ovf", overflow, 0);
      for (int i = 0; i < 64 && i < q_cyc.size(); i++) begin
         check("str_freq", q_freq[i], (i % 2 == 1) ? 15 : 1);
         check("str_peak", q_mag[i],
               (i % 2 == 1) ? 32'h0004_0000 : 32'h0001_0000);
         check("str_lat", q_cyc[i] - ts[i], 17);
      end
      clear_q();

      // overrun: three frames on consecutive cycles
      f    = '{default: '0};
      f[7] = 32'h8000_8000;
      pulse(f_lo, t);
      pulse(f_hi, t2);
      pulse(f, t3);
      check("ovr_pre", overflow, 0);
      quiet();
      check("ovr_set", overflow, 1);
      wait_done(2, 60);
      repeat (25) quiet();
      check("ovr_cnt", q_cyc.size(), 2);
      if (q_cyc.size() >= 2) begin
         check("ovr_lat1", q_cyc[0] - t, 17);
         check("ovr_lat2", q_cyc[1] - t, 33);
         check("ovr_f1", q_freq[0], 1);
         check("ovr_f2", q_freq[1], 15);
         check("ovr_p2", q_mag[1], 32'h0004_0000);
      end
      check("ovr_sticky", overflow, 1);
      check("ovr_idle", busy, 0);
      #2 rst = 1'b0;
      #1;
      check("ovr_clr", overflow, 0);
      @(negedge clk);
      rst = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fas_analysis.md
Name: fas_analysis

Overview:
- Analysis stage of the FAS chain, directly downstream of the 16-point FFT.
- Consumes each 16-bin FFT frame (fft_valid + fft_d0..fft_d15) and computes |X[k]|^2 = re^2 + im^2 per bin, one bin per cycle.
- Reports the index of the dominant bin on freq, with a one-cycle done pulse per frame.
- Double-buffers frames so it keeps up with FFT frames arriving every 16 cycles.

Parameters:
- NBIN, 16, bins per frame; power of 2.
- DW, 16, width of the real and imaginary parts: signed 8.8 two's complement.
- MW, 32, magnitude-squared width: unsigned.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- fft_valid  input  1  one-cycle strobe: fft_d0..fft_d15 hold a complete frame.
- fft_d0..fft_d15  input  32 each  bin k: [31:16] real, [15:0] imag, both signed 8.8.
- freq  output  4  index of the maximum-magnitude bin of the last finished frame.
- done  output  1  one-cycle pulse; freq and peak_mag are valid in this cycle.
- peak_mag  output  32  re^2+im^2 of the winning bin, unsigned 16.16.
- busy  output  1  high while a frame is being processed or is pending.
- overflow  output  1  sticky; set when a frame is dropped.

Behaviour:
- Reset (rst low, async) clears outputs, control and buffers:
  - freq=0, done=0, peak_mag=0, busy=0, overflow=0.
  - bank_full[1:0]=0, work pointer=0, bin counter=0, running max=0, running index=0.
  - Reset mid-frame abandons the frame; no done pulse is produced for it.
- Buffering: two frame banks (A, B), each 16x32 bits, each with a full flag.
  - On fft_valid, the frame is written to the bank that is not full; if both are empty, bank A.
  - Both banks full at fft_valid: frame discarded, overflow set to 1 (cleared only by reset), existing banks untouched.
  - A bank finishing its last bin while fft_valid arrives in the same cycle frees it for the write in that cycle.
- FSM states:
  - IDLE -> RUN when any bank is full; takes the oldest full bank; bin counter k=0; max=0; idx=0.
  - RUN: each cycle reads bin k of the work bank and forms m = re*re + im*im.
    - Products: signed 16x16 -> 32; each product >= 0, max 2^30; sum <= 2^31, fits 32 bits unsigned, no saturation.
    - k==0: max<=m, idx<=0. k>0 and m > max (strict): max<=m, idx<=k. Ties keep the lower index.
  - k==15 in RUN: next cycle freq<=final idx, peak_mag<=final max, done<=1.
    - Work bank's full flag cleared; work pointer toggles.
    - Next state is RUN (k=0) if the other bank is full, else IDLE.
- Latency:
  - fft_valid sampled at edge T, banks empty: bins 0..15 processed in cycles T+1..T+16; done high in cycle T+17.
  - Frames every 16 cycles give back-to-back done pulses 16 cycles apart with no overflow.
- freq and peak_mag hold their value between done pulses.
- busy = (state==RUN) | bank_full[0] | bank_full[1].
- All-zero frame: freq=0, peak_mag=0, done pulses normally.

Decomposition:
- Shared package fas_pkg holds:
  - NBIN, DW, MW constants.
  - Typedef cplx_t: packed struct {logic signed [15:0] re; logic signed [15:0] im;}.
  - Typedef mag_t: logic [31:0].
  - Typedef state_t enum: IDLE, RUN.
- One sub-module, fas_mag_sq: purely combinational cplx_t -> mag_t (two signed multipliers, one adder). Instantiated once.
- Bank storage, FSM and compare logic live in fas_analysis.

Test Plan:
- Reset check: rst low mid-RUN, then released -> freq=0, done=0, peak_mag=0, busy=0, overflow=0; no done pulse within 20 cycles.
- Single tone: bin1=0x0100_0000, bin15=0x0000_0080, others 0 -> done exactly 17 cycles after fft_valid; freq=1, peak_mag=0x0001_0000.
- Tie and negatives: bin3=0xFF00_0000, bin9=0x0000_0100, others 0 -> freq=3, peak_mag=0x0001_0000 (lower index wins on tie).
- Extreme value: bin7=0x8000_8000 -> peak_mag=0x8000_0000, freq=7, no wrap.
- Streaming: 64 frames, fft_valid every 16 cycles, dominant bin alternating 1/15 -> 64 done pulses spaced 16 cycles, freq sequence matches, overflow=0.
- Overrun: three fft_valid in cycles T, T+1, T+2 -> frames 1 and 2 reported (done at T+17 and T+33); frame 3 dropped; overflow=1 from T+3 onward.
